fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation core. Replaces the single-cycle core's combinational PC → instruction-memory path.
- Issues word-aligned fetch requests to an instruction memory with variable latency, using a valid/ready request and an in-order response.
- Buffers returned instructions with their PCs in a DEPTH-entry prefetch queue, which feeds decode over a valid/ready handshake.
- Handles redirects from branch/JAL/JALR resolution by flushing the queue and discarding stale in-flight responses.

Parameters:
- XLEN, 32, address and instruction width in bits.
- DEPTH, 4, queue entries; also the maximum of (queued + in-flight) requests. Power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_req_addr  output  XLEN  fetch address, word aligned.
- imem_rsp_valid  input  1  response valid; at most one per cycle, in request order.
- imem_rsp_data  input  XLEN  returned instruction.
- if_valid  output  1  queue head valid toward decode.
- if_ready  input  1  decode consumes the head.
- if_instr  output  XLEN  head instruction.
- if_pc  output  XLEN  head PC.
- redirect_valid  input  1  redirect fetch stream; single-cycle pulse.
- redirect_pc  input  XLEN  new fetch target.

Behaviour:
- **State:**
  - fetch_pc: next request address.
  - rsp_pc: PC of the next accepted response.
  - occ: queue occupancy, 0..DEPTH.
  - outstanding: requests accepted by memory, response not yet seen.
  - drop_cnt: responses still to discard.
  - Counters are $clog2(DEPTH+1) bits wide.
- **Reset (rst=0, asynchronous):**
  - fetch_pc=rsp_pc=RESET_PC; occ=outstanding=drop_cnt=0; queue pointers 0.
  - Outputs: imem_req_valid=0, if_valid=0, if_instr=0, if_pc=0.
  - The first request is issued in the first cycle after rst deasserts.
- **Request:**
  - imem_req_valid = (occ + outstanding < DEPTH) && !redirect_valid.
  - imem_req_addr = fetch_pc, held stable while valid && !ready.
  - On fire (valid && ready): fetch_pc += 4, wrapping modulo 2^XLEN; outstanding += 1.
- **Response (imem_rsp_valid=1):**
  - outstanding −= 1.
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Else: push {rsp_pc, imem_rsp_data} into the queue and set rsp_pc += 4.
  - A response with outstanding==0 is a protocol violation: ignore it; no state change.
- **Dequeue:**
  - if_valid = (occ != 0). if_instr/if_pc are the head entry; 0 when empty.
  - On if_valid && if_ready: pop.
  - Push and pop in the same cycle leave occ unchanged. No overflow is possible by the credit rule.
  - Latency: a response arriving in cycle N is visible on if_* in cycle N+1. Zero bypass.
- **Redirect (redirect_valid=1), highest priority:**
  - Queue flushed: occ=0, pointers reset. Any same-cycle pop or push is ignored.
  - No request is issued this cycle.
  - fetch_pc = rsp_pc = {redirect_pc[XLEN-1:2], 2'b00}; low bits are forced to zero.
  - A response arriving in the redirect cycle is discarded: drop_cnt_next = outstanding − rsp_valid; outstanding_next = outstanding − rsp_valid.
  - A redirect while drop_cnt>0 recomputes drop_cnt by the same formula.
  - if_valid=0 in the cycle after a redirect unless the queue was refilled. First post-redirect instruction: if_pc = redirect_pc with low bits cleared.
- **Reset mid-operation:** all state clears immediately; in-flight responses after reset release are not expected (memory is reset too).

Test Plan:
- Streaming: release reset; RESET_PC=0; imem_req_ready=1; 1-cycle memory with mem[i]=0x1000+i; if_ready=1 → requests 0x0,0x4,0x8…; if_pc 0x0,0x4,0x8 with if_instr 0x1000,0x1001,0x1002; steady state one instruction per cycle.
- Backpressure: if_ready=0, DEPTH=4 → exactly 4 requests fire, then imem_req_valid=0 with occ=4; raise if_ready → if_pc 0x0..0xC in order, no loss or duplicate; fetching resumes at 0x10.
- Redirect with in-flight: 3-cycle memory, 2 outstanding, redirect_pc=0x103 → next 2 responses dropped; first if_pc=0x100, then 0x104; queue empty during the drop window.
- Same-cycle redirect and response: redirect to 0x200 exactly when a response arrives with outstanding=1 → that response is dropped; drop_cnt=0; next issued address 0x200; head if_pc=0x200.
- Request stall: imem_req_ready=0 for 5 cycles → imem_req_addr stable at the pending address; fetch_pc unchanged; after ready, addresses continue +4 with no skip.
- Async reset mid-stream: assert rst=0 between clock edges with occ=3 → if_valid and imem_req_valid go 0 immediately; after release, first request addr = RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited request issue toward a
// variable-latency in-order instruction memory, a DEPTH-entry prefetch queue
// feeding decode, and redirect handling that flushes the queue and discards
// responses to requests issued before the redirect.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned PW = $clog2(DEPTH);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0] instr_q [DEPTH];
    logic [XLEN-1:0] instr_d [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [XLEN-1:0] pc_d    [DEPTH];

    logic            credit_ok;
    logic            req_fire;
    logic            rsp_fire;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redirect_aligned;

    // Request credit: queued entries plus in-flight requests never exceed DEPTH
    assign credit_ok        = (SW'(occ_q) + SW'(outstanding_q)) < SW'(DEPTH);
    assign imem_req_valid   = rst && credit_ok && !redirect_valid;
    assign imem_req_addr    = fetch_pc_q;
    assign if_valid         = (occ_q != '0);
    assign if_instr         = if_valid ? instr_q[rd_ptr_q] : '0;
    assign if_pc            = if_valid ? pc_q[rd_ptr_q] : '0;
    assign redirect_aligned = redirect_pc & ALIGN_MASK;

    // Handshake events; a response with nothing outstanding is ignored entirely
    always_comb begin
        req_fire = imem_req_valid && imem_req_ready;
        rsp_fire = imem_rsp_valid && (outstanding_q != '0);
        push     = rsp_fire && (drop_cnt_q == '0) && !redirect_valid;
        pop      = if_valid && if_ready && !redirect_valid;
    end

    // Next-state for PCs, counters and queue pointers; redirect takes priority
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        occ_d         = occ_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
        drop_cnt_d    = drop_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_aligned;
            rsp_pc_d   = redirect_aligned;
            occ_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            // every request still outstanding after this cycle is stale
            drop_cnt_d = outstanding_q - CW'(rsp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (rsp_fire && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + PC_STEP;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            occ_d = occ_q + CW'(push) - CW'(pop);
        end
    end

    // Queue storage write
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        if (push) begin
            instr_d[wr_ptr_q] = imem_rsp_data;
            pc_d[wr_ptr_q]    = rsp_pc_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC & ALIGN_MASK;
            rsp_pc_q      <= RESET_PC & ALIGN_MASK;
            occ_q         <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            occ_q         <= occ_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: a latency-modelled instruction memory plus
// a transaction-level reference (expected fetch stream, epoch-tagged
// in-flight requests, queue of expected decode entries).
module tb_fetch_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int unsigned due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    req_t        pending[$];
    ent_t        mq[$];
    logic [31:0] m_fetch_pc;
    int unsigned epoch;
    int unsigned cycle;
    int unsigned last_due;

    int unsigned lat_min, lat_max, rdy_pct, ifr_pct, redir_pct;
    bit          spurious_en;

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000 + (addr >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // One clock cycle: called just after a falling edge
    task automatic step();
        bit          present;
        bit          exp_req_valid;
        bit          exp_if_valid;
        bit          do_pop;
        int unsigned lat;
        int unsigned due;
        req_t        r;
        ent_t        e;

        cycle++;
        present = (pending.size() != 0) && (pending[0].due <= cycle);
        if (present) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pending[0].addr);
        end else if (spurious_en && pending.size() == 0 && $urandom_range(0, 15) == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        redirect_valid = ($urandom_range(0, 99) < redir_pct);
        redirect_pc    = 32'h100 + 32'($urandom_range(0, 1023));
        if_ready       = ($urandom_range(0, 99) < ifr_pct);
        imem_req_ready = ($urandom_range(0, 99) < rdy_pct);

        #1;
        exp_req_valid = ((mq.size() + pending.size()) < DEPTH) && !redirect_valid;
        exp_if_valid  = (mq.size() != 0);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_req_valid));
        if (exp_req_valid) chk("req_addr", imem_req_addr, m_fetch_pc);
        chk("if_valid", 32'(if_valid), 32'(exp_if_valid));
        chk("if_pc", if_pc, exp_if_valid ? mq[0].pc : 32'h0);
        chk("if_instr", if_instr, exp_if_valid ? mq[0].instr : 32'h0);

        @(posedge clk);
        do_pop = !redirect_valid && exp_if_valid && if_ready;
        if (do_pop) void'(mq.pop_front());
        if (present) begin
            r = pending.pop_front();
            if (!redirect_valid && r.epoch == epoch) begin
                e.pc    = r.addr;
                e.instr = mem_word(r.addr);
                mq.push_back(e);
            end
        end
        if (exp_req_valid && imem_req_ready) begin
            lat = $urandom_range(lat_min, lat_max);
            due = cycle + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.addr  = m_fetch_pc;
            r.epoch = epoch;
            r.due   = due;
            pending.push_back(r);
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        if (redirect_valid) begin
            mq.delete();
            epoch++;
            m_fetch_pc = redirect_pc & ~32'd3;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cfg(input int unsigned lmin, input int unsigned lmax, input int unsigned rdy,
                       input int unsigned ifr, input int unsigned redir, input bit spur);
        lat_min = lmin; lat_max = lmax; rdy_pct = rdy;
        ifr_pct = ifr; redir_pct = redir; spurious_en = spur;
    endtask

    task automatic model_reset();
        pending.delete();
        mq.delete();
        m_fetch_pc = RESET_PC;
        epoch++;
        last_due = cycle;
    endtask

    initial begin
        bool_filled_t: begin end
        epoch = 0;
        cycle = 0;
        model_reset();
        cfg(1, 1, 100, 100, 0, 1'b0);

        // reset state
        #2;
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // streaming with a 1-cycle memory
        run(30);
        // backpressure from decode, then drain
        cfg(1, 1, 100, 0, 0, 1'b0);
        run(10);
        cfg(1, 1, 100, 100, 0, 1'b0);
        run(10);
        // request stall
        cfg(1, 1, 0, 100, 0, 1'b0);
        run(6);
        cfg(1, 1, 100, 100, 0, 1'b0);
        run(6);
        // 3-cycle memory with redirects and in-flight drops
        cfg(3, 3, 100, 100, 6, 1'b0);
        run(150);
        // fully random mix, including stray responses
        cfg(1, 5, 70, 70, 5, 1'b1);
        run(1500);

        // async reset mid-stream with the queue partly filled
        cfg(1, 1, 100, 0, 0, 1'b0);
        for (int i = 0; i < 20 && mq.size() < 3; i++) step();
        chk("prefill_occ", 32'(mq.size() >= 3), 32'h1);
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async_if_valid", 32'(if_valid), 32'h0);
        chk("async_req_valid", 32'(imem_req_valid), 32'h0);
        chk("async_if_pc", if_pc, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cfg(1, 3, 80, 80, 3, 1'b0);
        run(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
